counter_top_write: RTL
======================

# counter_top_write

Write-side BRAM accessor: on a start pulse it accepts `cnt_val_i` data words from an upstream valid/ready stream and writes them to consecutive BRAM addresses from 0 upward. It drives the BRAM port directly from registers and reports idle/run/done status to the controlling top-level FSM. It is the write counterpart of the read accessor and is used to fill a BRAM before a read pass.

## Interface
- `AWIDTH`, 8, BRAM address width.
- `DWIDTH`, 32, BRAM data width.
- `CNT_BIT`, 31, width of the word-count request and the internal beat counter.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start pulse; accepted only in IDLE.
- `cnt_val_i`  in  CNT_BIT  number of words to write; latched when `start_i` is accepted.
- `s_valid_i`  in  1  upstream word valid.
- `s_data_i`  in  DWIDTH  upstream word.
- `s_ready_o`  out  1  block can accept a word this cycle.
- `addr_o`  out  AWIDTH  BRAM address (registered).
- `ce_o`  out  1  BRAM chip enable (registered).
- `we_o`  out  1  BRAM write enable (registered).
- `d_o`  out  DWIDTH  BRAM write data (registered).
- `write_idle_o`  out  1  state == IDLE.
- `write_run_o`  out  1  state == RUN.
- `write_done_o`  out  1  state == DONE (one-cycle pulse).

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free; status outputs are decoded from the state register.
- IDLE: `s_ready_o` = 0.
  - On `start_i` = 1, latch `cnt_val_i` into `num_r` and clear beat counter `cnt_r`.
  - If `cnt_val_i` != 0, go to RUN.
  - If `cnt_val_i` == 0, go straight to DONE; no write is issued.
- RUN: `s_ready_o` = 1.
  - A beat is `s_valid_i & s_ready_o`.
  - On each beat, register `addr_o` <= `cnt_r[AWIDTH-1:0]`, `d_o` <= `s_data_i`, `ce_o` = `we_o` <= 1, and increment `cnt_r`.
  - Cycles without a beat register `ce_o` = `we_o` = 0; `addr_o` and `d_o` hold.
  - On the beat where `cnt_r == num_r - 1`, go to DONE.
- DONE: `s_ready_o` = 0, `cnt_r` cleared, unconditional return to IDLE on the next edge.
- `start_i` in RUN or DONE is ignored. Changes on `cnt_val_i` after latching are ignored.
- Arithmetic:
  - `cnt_r` and `num_r` are CNT_BIT wide; the comparison uses the full width.
  - The address is the low AWIDTH bits of `cnt_r`, so it wraps modulo 2^AWIDTH when `num_r` > 2^AWIDTH. Wrapped writes overwrite earlier ones; this is not flagged.
- Reset (asserted any time, including mid-RUN) immediately gives:
  - state = IDLE, `cnt_r` = `num_r` = 0;
  - `addr_o` = 0, `d_o` = 0, `ce_o` = `we_o` = 0, `s_ready_o` = 0;
  - `write_idle_o` = 1, `write_run_o` = `write_done_o` = 0.
- A partially filled BRAM after reset is not cleaned up.

## Timing
- Start: `start_i` sampled high at edge E in IDLE gives `write_run_o` = 1 and `s_ready_o` = 1 from E.
- Write latency: a beat at edge k drives `we_o` = 1 with the matching `addr_o`/`d_o` during cycle k..k+1. The BRAM captures it at edge k+1.
- Last beat at edge L:
  - `write_done_o` = 1 and the last `we_o` = 1 both hold during cycle L..L+1;
  - `write_idle_o` = 1 from L+1.
- Minimum transaction time for N words with continuous valid: N cycles in RUN + 1 cycle in DONE.
- `cnt_val_i` = 0: DONE for one cycle after the start edge, then IDLE.
- `s_ready_o` is a function of state only; there is no combinational path from `s_valid_i`.

## Test plan
- Reset: hold `reset_n` = 0, then release → idle = 1, run = done = 0, `ce_o` = `we_o` = 0, `addr_o` = 0, `s_ready_o` = 0.
- Basic: start with `cnt_val_i` = 4 and continuous valid with data A0..A3 → addresses 0..3 written with A0..A3 on 4 consecutive cycles; `write_done_o` high during the 4th `we_o` cycle; idle on the next cycle.
- Bubbles: `cnt_val_i` = 3, `s_valid_i` pattern 1,0,0,1,0,1 → `we_o` pattern 1,0,0,1,0,1 one cycle later; addresses 0,1,2; exactly 3 writes; done after the third.
- Zero length: `cnt_val_i` = 0 → no `we_o`, `s_ready_o` never high, done pulse on the cycle after start.
- Wrap: AWIDTH = 8, `cnt_val_i` = 258 → 258 writes; addresses 254,255,0,1 at beats 254..257; done after beat 257.
- Robustness:
  - `start_i` pulsed with `cnt_val_i` = 9 during RUN of a 5-word transfer → ignored; exactly 5 writes.
  - `reset_n` asserted after beat 2 → outputs return to reset values immediately; a new start with 2 words writes addresses 0,1.

Source files
------------

// File: rtl/counter_top_write.sv
// Write-side BRAM accessor: streams cnt_val_i words from a valid/ready source
// into consecutive BRAM addresses starting at 0, with idle/run/done status.
module counter_top_write #(
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned CNT_BIT = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [CNT_BIT-1:0] cnt_val_i,
  input  logic               s_valid_i,
  input  logic [DWIDTH-1:0]  s_data_i,
  output logic               s_ready_o,
  output logic [AWIDTH-1:0]  addr_o,
  output logic               ce_o,
  output logic               we_o,
  output logic [DWIDTH-1:0]  d_o,
  output logic               write_idle_o,
  output logic               write_run_o,
  output logic               write_done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_BIT-1:0] CNT_ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [CNT_BIT-1:0] num_q, num_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [DWIDTH-1:0]  dat_q, dat_d;
  logic               wr_q, wr_d;
  logic               beat;

  assign beat = (state_q == S_RUN) && s_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    wr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_d   = cnt_val_i;
          cnt_d   = '0;
          state_d = (cnt_val_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (beat) begin
          // Address wraps on the low bits; the end test uses the full counter.
          addr_d = cnt_q[AWIDTH-1:0];
          dat_d  = s_data_i;
          wr_d   = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == num_q - CNT_ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
    end
  end

  assign s_ready_o    = (state_q == S_RUN);
  assign addr_o       = addr_q;
  assign d_o          = dat_q;
  assign ce_o         = wr_q;
  assign we_o         = wr_q;
  assign write_idle_o = (state_q == S_IDLE);
  assign write_run_o  = (state_q == S_RUN);
  assign write_done_o = (state_q == S_DONE);

endmodule
